// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding and a width helper
// that never yields a zero-width vector.
package bus_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_TURN   = 2'd3;

    // $clog2 clamped to at least one bit, so a 2-entry or 1-limit field stays legal
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter-side bus signals. The arbiter uses the master modport; requesters and
// the resolved slave busy line sit behind the slave modport.
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    import bus_pkg::*;

    localparam int ID_W = safe_clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] req;
    logic                   slave_busy;
    logic [NUM_MASTERS-1:0] grant;
    logic                   bus_util;
    logic [ID_W-1:0]        grant_id;
    logic                   timeout;
    logic [ID_W-1:0]        timeout_id;

    modport master (
        input  req, slave_busy,
        output grant, bus_util, grant_id, timeout, timeout_id
    );

    modport slave (
        output req, slave_busy,
        input  grant, bus_util, grant_id, timeout, timeout_id
    );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: first eligible requester scanning upward from rr_ptr,
// wrapping at N. Purely combinational so it can be shared by wider arbiters.
module rr_picker #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    elig,
    input  logic [ID_W-1:0] rr_ptr,
    output logic            vld,
    output logic [ID_W-1:0] idx
);

    // Scan from the farthest offset down so the nearest eligible index wins
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int pos;
            pos = (int'(rr_ptr) + k) % N;
            if (elig[pos]) begin
                vld = 1'b1;
                idx = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one grant at a time, waits for slaves to go idle,
// then holds the bus quiet for a turnaround before the next grant. A watchdog
// revokes over-long grants and masks the offender until it drops req.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS       = 2,
    parameter int MAX_GRANT_CYCLES  = 1023,
    parameter int TURNAROUND_CYCLES = 2,
    parameter int MAX_SETTLE_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);

    localparam int ID_W     = safe_clog2(NUM_MASTERS);
    localparam int HOLD_W   = safe_clog2(MAX_GRANT_CYCLES);
    localparam int SETTLE_W = safe_clog2(MAX_SETTLE_CYCLES);
    localparam int TURN_W   = safe_clog2(TURNAROUND_CYCLES);

    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(MAX_GRANT_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(MAX_SETTLE_CYCLES - 1);
    localparam logic [TURN_W-1:0]   TURN_LAST   = TURN_W'(TURNAROUND_CYCLES - 1);

    logic [1:0]             state;
    logic [ID_W-1:0]        rr_ptr;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic [TURN_W-1:0]      turn_cnt;
    logic [NUM_MASTERS-1:0] mask;

    logic [NUM_MASTERS-1:0] grant_r;
    logic                   bus_util_r;
    logic [ID_W-1:0]        grant_id_r;
    logic                   timeout_r;
    logic [ID_W-1:0]        timeout_id_r;

    logic                   pick_vld;
    logic [ID_W-1:0]        pick_idx;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_MASTERS-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        return (int'(id) == NUM_MASTERS - 1) ? '0 : id + 1'b1;
    endfunction

    rr_picker #(
        .N    (NUM_MASTERS),
        .ID_W (ID_W)
    ) u_picker (
        .elig   (bus.req & ~mask),
        .rr_ptr (rr_ptr),
        .vld    (pick_vld),
        .idx    (pick_idx)
    );

    // Arbitration FSM; a mask bit set by the watchdog survives only while req stays high
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            hold_cnt     <= '0;
            settle_cnt   <= '0;
            turn_cnt     <= '0;
            mask         <= '0;
            grant_r      <= '0;
            bus_util_r   <= 1'b0;
            grant_id_r   <= '0;
            timeout_r    <= 1'b0;
            timeout_id_r <= '0;
        end else begin
            timeout_r <= 1'b0;
            mask      <= mask & bus.req;
            case (state)
                ST_IDLE: begin
                    if (pick_vld && !bus.slave_busy) begin
                        grant_r    <= onehot(pick_idx);
                        bus_util_r <= 1'b1;
                        grant_id_r <= pick_idx;
                        hold_cnt   <= '0;
                        state      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!bus.req[grant_id_r]) begin
                        grant_r    <= '0;
                        bus_util_r <= 1'b0;
                        rr_ptr     <= wrap_inc(grant_id_r);
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        grant_r      <= '0;
                        bus_util_r   <= 1'b0;
                        rr_ptr       <= wrap_inc(grant_id_r);
                        timeout_r    <= 1'b1;
                        timeout_id_r <= grant_id_r;
                        mask         <= (mask & bus.req) | onehot(grant_id_r);
                        settle_cnt   <= '0;
                        state        <= ST_SETTLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!bus.slave_busy) begin
                        turn_cnt <= '0;
                        state    <= ST_TURN;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        timeout_r    <= 1'b1;
                        timeout_id_r <= grant_id_r;
                        turn_cnt     <= '0;
                        state        <= ST_TURN;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant      = grant_r;
    assign bus.bus_util   = bus_util_r;
    assign bus.grant_id   = grant_id_r;
    assign bus.timeout    = timeout_r;
    assign bus.timeout_id = timeout_id_r;

endmodule
